udp_echo_engine: RTL and testbench

UDP_ECHO_ENGINE -- requirements
Module: udp_echo_engine

---
 rtl/udp_echo_pkg.sv | 22 ++
 rtl/udp_echo_buf.sv | 30 +++
 rtl/udp_echo_engine.sv | 187 ++++++++++++++++++
 tb/tb_udp_echo_engine.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_echo_pkg.sv
// Shared types and constants for the UDP echo engine.
// Holds the FSM state encoding, the latched UDP header record and the default echo port.
package udp_echo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    DROP,
    TX_HDR,
    TX_PL
  } state_t;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } udp_hdr_t;

  localparam logic [15:0] DEFAULT_ECHO_PORT = 16'd1234;

endpackage

// File: rtl/udp_echo_buf.sv
// Simple dual-port payload buffer with a registered read port.
// The read register holds its value while i_rd_en is low, which keeps stalled output beats stable.
module udp_echo_buf #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/udp_echo_engine.sv
// UDP echo engine: buffers one received datagram, then sends it back to its sender
// with source and destination ports swapped. Bad or oversized frames are dropped.
module udp_echo_engine
  import udp_echo_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 256,
  parameter bit          FILTER_EN = 1'b1,
  parameter logic [15:0] ECHO_PORT = DEFAULT_ECHO_PORT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_hdr_valid,
  output logic                s_hdr_ready,
  input  logic [31:0]         s_ip_src,
  input  logic [15:0]         s_src_port,
  input  logic [15:0]         s_dst_port,
  input  logic [15:0]         s_length,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic                s_tuser,
  output logic                m_hdr_valid,
  input  logic                m_hdr_ready,
  output logic [31:0]         m_ip_dst,
  output logic [15:0]         m_src_port,
  output logic [15:0]         m_dst_port,
  output logic [15:0]         m_length,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                m_tuser,
  output logic [31:0]         stat_rx,
  output logic [31:0]         stat_tx,
  output logic [31:0]         stat_drop
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int WORD_W = 1 + KEEP_W + DATA_W;

  state_t      r_state;
  udp_hdr_t    r_hdr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic        r_s_hdr_ready;
  logic        r_s_tready;
  logic        r_m_hdr_valid;
  logic        r_m_tvalid;
  logic [31:0] r_stat_rx;
  logic [31:0] r_stat_tx;
  logic [31:0] r_stat_drop;

  logic              w_full;
  logic              w_s_beat;
  logic              w_port_ok;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_rd_tlast;

  // Only one frame is ever buffered, so the read pointer marks the start of the frame being received.
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_s_beat   = s_tvalid && r_s_tready;
  assign w_port_ok  = (FILTER_EN == 1'b0) || (s_dst_port == ECHO_PORT);
  assign w_wr_en    = (r_state == RX) && w_s_beat && !w_full;
  assign w_rd_en    = (r_state == TX_PL) && (r_rd_ptr != r_wr_ptr) && (!r_m_tvalid || m_tready);
  assign w_wr_word  = {s_tlast, s_tkeep, s_tdata};
  assign w_rd_tlast = w_rd_word[WORD_W-1];

  udp_echo_buf #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr[AW-1:0]),
    .i_wr_data(w_wr_word),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(r_rd_ptr[AW-1:0]),
    .o_rd_data(w_rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_hdr         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_s_hdr_ready <= 1'b0;
      r_s_tready    <= 1'b0;
      r_m_hdr_valid <= 1'b0;
      r_m_tvalid    <= 1'b0;
      r_stat_rx     <= '0;
      r_stat_tx     <= '0;
      r_stat_drop   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_s_hdr_ready <= 1'b1;
          if (s_hdr_valid && r_s_hdr_ready) begin
            r_hdr         <= '{ip: s_ip_src, src_port: s_src_port, dst_port: s_dst_port, length: s_length};
            r_stat_rx     <= r_stat_rx + 32'd1;
            r_s_hdr_ready <= 1'b0;
            r_s_tready    <= 1'b1;
            r_state       <= w_port_ok ? RX : DROP;
          end
        end
        RX: begin
          if (w_s_beat) begin
            // Overflow and a bad last beat both discard everything written for this frame.
            if (w_full || (s_tlast && s_tuser)) begin
              r_wr_ptr <= r_rd_ptr;
              if (s_tlast) begin
                r_stat_drop   <= r_stat_drop + 32'd1;
                r_s_tready    <= 1'b0;
                r_s_hdr_ready <= 1'b1;
                r_state       <= IDLE;
              end else begin
                r_state <= DROP;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              if (s_tlast) begin
                r_s_tready    <= 1'b0;
                r_m_hdr_valid <= 1'b1;
                r_state       <= TX_HDR;
              end
            end
          end
        end
        DROP: begin
          if (w_s_beat && s_tlast) begin
            r_stat_drop   <= r_stat_drop + 32'd1;
            r_s_tready    <= 1'b0;
            r_s_hdr_ready <= 1'b1;
            r_state       <= IDLE;
          end
        end
        TX_HDR: begin
          if (m_hdr_ready) begin
            r_m_hdr_valid <= 1'b0;
            r_state       <= TX_PL;
          end
        end
        TX_PL: begin
          if (w_rd_en) begin
            r_rd_ptr   <= r_rd_ptr + PW'(1);
            r_m_tvalid <= 1'b1;
          end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
          end
          if (r_m_tvalid && m_tready && w_rd_tlast) begin
            r_stat_tx     <= r_stat_tx + 32'd1;
            r_m_tvalid    <= 1'b0;
            r_s_hdr_ready <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_hdr_ready = r_s_hdr_ready;
  assign s_tready    = r_s_tready;
  assign m_hdr_valid = r_m_hdr_valid;
  assign m_ip_dst    = r_hdr.ip;
  assign m_src_port  = r_hdr.dst_port;
  assign m_dst_port  = r_hdr.src_port;
  assign m_length    = r_hdr.length;
  assign m_tdata     = w_rd_word[DATA_W-1:0];
  assign m_tkeep     = w_rd_word[DATA_W +: KEEP_W];
  assign m_tlast     = w_rd_tlast;
  assign m_tvalid    = r_m_tvalid;
  assign m_tuser     = 1'b0;
  assign stat_rx     = r_stat_rx;
  assign stat_tx     = r_stat_tx;
  assign stat_drop   = r_stat_drop;

endmodule

// File: tb/tb_udp_echo_engine.sv
// Scoreboard bench for udp_echo_engine: an 8-bit/16-deep instance and a 64-bit instance
// share one set of drivers, selected by 'sel'; expected headers and beats are queued as stimulus is driven.
module tb_udp_echo_engine;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } exp_hdr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        s_hdr_valid = 1'b0;
  logic [31:0] s_ip_src = '0;
  logic [15:0] s_src_port = '0;
  logic [15:0] s_dst_port = '0;
  logic [15:0] s_length = '0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        m_hdr_ready = 1'b0;
  logic        m_tready = 1'b0;

  logic        a_s_hdr_ready, a_s_tready, a_m_hdr_valid, a_m_tvalid, a_m_tlast, a_m_tuser;
  logic [31:0] a_m_ip_dst, a_stat_rx, a_stat_tx, a_stat_drop;
  logic [15:0] a_m_src_port, a_m_dst_port, a_m_length;
  logic [7:0]  a_m_tdata;
  logic [0:0]  a_m_tkeep;

  logic        b_s_hdr_ready, b_s_tready, b_m_hdr_valid, b_m_tvalid, b_m_tlast, b_m_tuser;
  logic [31:0] b_m_ip_dst, b_stat_rx, b_stat_tx, b_stat_drop;
  logic [15:0] b_m_src_port, b_m_dst_port, b_m_length;
  logic [63:0] b_m_tdata;
  logic [7:0]  b_m_tkeep;

  udp_echo_engine #(.DATA_W(8), .DEPTH(16), .FILTER_EN(1'b1), .ECHO_PORT(16'd1234)) u_dut_a (
    .clk(clk), .reset(reset),
    .s_hdr_valid(s_hdr_valid & ~sel), .s_hdr_ready(a_s_hdr_ready),
    .s_ip_src(s_ip_src), .s_src_port(s_src_port), .s_dst_port(s_dst_port), .s_length(s_length),
    .s_tdata(s_tdata[7:0]), .s_tkeep(s_tkeep[0:0]), .s_tvalid(s_tvalid & ~sel), .s_tready(a_s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_hdr_valid(a_m_hdr_valid), .m_hdr_ready(m_hdr_ready & ~sel),
    .m_ip_dst(a_m_ip_dst), .m_src_port(a_m_src_port), .m_dst_port(a_m_dst_port), .m_length(a_m_length),
    .m_tdata(a_m_tdata), .m_tkeep(a_m_tkeep), .m_tvalid(a_m_tvalid), .m_tready(m_tready & ~sel),
    .m_tlast(a_m_tlast), .m_tuser(a_m_tuser),
    .stat_rx(a_stat_rx), .stat_tx(a_stat_tx), .stat_drop(a_stat_drop)
  );

  udp_echo_engine #(.DATA_W(64), .DEPTH(16), .FILTER_EN(1'b1), .ECHO_PORT(16'd1234)) u_dut_b (
    .clk(clk), .reset(reset),
    .s_hdr_valid(s_hdr_valid & sel), .s_hdr_ready(b_s_hdr_ready),
    .s_ip_src(s_ip_src), .s_src_port(s_src_port), .s_dst_port(s_dst_port), .s_length(s_length),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid & sel), .s_tready(b_s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_hdr_valid(b_m_hdr_valid), .m_hdr_ready(m_hdr_ready & sel),
    .m_ip_dst(b_m_ip_dst), .m_src_port(b_m_src_port), .m_dst_port(b_m_dst_port), .m_length(b_m_length),
    .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep), .m_tvalid(b_m_tvalid), .m_tready(m_tready & sel),
    .m_tlast(b_m_tlast), .m_tuser(b_m_tuser),
    .stat_rx(b_stat_rx), .stat_tx(b_stat_tx), .stat_drop(b_stat_drop)
  );

  logic        w_hdr_ready, w_s_tready, w_m_hdr_valid, w_m_tvalid, w_m_tlast, w_m_tuser;
  logic [31:0] w_ip_dst, w_rx, w_tx, w_drop;
  logic [15:0] w_src_port, w_dst_port, w_length;
  logic [63:0] w_m_tdata;
  logic [7:0]  w_m_tkeep;

  assign w_hdr_ready   = sel ? b_s_hdr_ready : a_s_hdr_ready;
  assign w_s_tready    = sel ? b_s_tready    : a_s_tready;
  assign w_m_hdr_valid = sel ? b_m_hdr_valid : a_m_hdr_valid;
  assign w_m_tvalid    = sel ? b_m_tvalid    : a_m_tvalid;
  assign w_m_tlast     = sel ? b_m_tlast     : a_m_tlast;
  assign w_m_tuser     = sel ? b_m_tuser     : a_m_tuser;
  assign w_ip_dst      = sel ? b_m_ip_dst    : a_m_ip_dst;
  assign w_src_port    = sel ? b_m_src_port  : a_m_src_port;
  assign w_dst_port    = sel ? b_m_dst_port  : a_m_dst_port;
  assign w_length      = sel ? b_m_length    : a_m_length;
  assign w_m_tdata     = sel ? b_m_tdata     : {56'b0, a_m_tdata};
  assign w_m_tkeep     = sel ? b_m_tkeep     : {7'b0, a_m_tkeep};
  assign w_rx          = sel ? b_stat_rx     : a_stat_rx;
  assign w_tx          = sel ? b_stat_tx     : a_stat_tx;
  assign w_drop        = sel ? b_stat_drop   : a_stat_drop;

  int       total = 0;
  int       bad = 0;
  beat_t    stim [0:31];
  beat_t    expQ [$];
  exp_hdr_t hdrQ [$];

  task automatic do_reset();
    reset = 1'b1;
    s_hdr_valid = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    m_hdr_ready = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    hdrQ.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      stim[i].data = {56'b0, base + 8'(i)};
      stim[i].keep = 8'h01;
      stim[i].last = 1'b0;
    end
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                          input logic [15:0] len, input bit echo);
    int cyc;
    exp_hdr_t h;
    s_ip_src = ip;
    s_src_port = sp;
    s_dst_port = dp;
    s_length = len;
    s_hdr_valid = 1'b1;
    cyc = 0;
    while (!w_hdr_ready && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!w_hdr_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL hdr_accept_timeout got s_hdr_ready=%0b want 1", w_hdr_ready);
    end else begin
      @(posedge clk);
      #1;
      if (echo) begin
        h.ip = ip;
        h.src_port = dp;
        h.dst_port = sp;
        h.length = len;
        hdrQ.push_back(h);
      end
    end
    s_hdr_valid = 1'b0;
  endtask

  task automatic send_payload(input int n_send, input int n_total, input bit bad_last,
                              input bit echo, output int stalls);
    int cyc;
    beat_t b;
    stalls = 0;
    for (int i = 0; i < n_send; i++) begin
      s_tdata = stim[i].data;
      s_tkeep = stim[i].keep;
      s_tlast = (i == n_total - 1);
      s_tuser = bad_last && (i == n_total - 1);
      s_tvalid = 1'b1;
      if (echo) begin
        b = stim[i];
        b.last = (i == n_total - 1);
        expQ.push_back(b);
      end
      if (!w_s_tready) stalls++;
      cyc = 0;
      while (!w_s_tready && cyc < 50) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!w_s_tready) begin
        total++;
        bad++;
        $display("[TB] FAIL beat_accept_timeout beat=%0d got s_tready=%0b want 1", i, w_s_tready);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
  endtask

  task automatic collect(input int budget);
    int cyc;
    bit done;
    bit prev_stall;
    logic [72:0] prev_word;
    exp_hdr_t eh;
    beat_t eb;
    cyc = 0;
    while (!w_m_hdr_valid && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (!w_m_hdr_valid || hdrQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL hdr_out got m_hdr_valid=%0b queued=%0d want valid with a queued header",
               w_m_hdr_valid, hdrQ.size());
      return;
    end
    eh = hdrQ.pop_front();
    if ({w_ip_dst, w_src_port, w_dst_port, w_length} !== eh) begin
      bad++;
      $display("[TB] FAIL hdr_fields got %h want %h", {w_ip_dst, w_src_port, w_dst_port, w_length}, eh);
    end
    m_hdr_ready = 1'b1;
    @(posedge clk);
    #1;
    m_hdr_ready = 1'b0;
    done = 1'b0;
    prev_stall = 1'b0;
    prev_word = '0;
    cyc = 0;
    while (!done && cyc < budget) begin
      m_tready = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        total++;
        if (!w_m_tvalid || {w_m_tdata, w_m_tkeep, w_m_tlast} !== prev_word) begin
          bad++;
          $display("[TB] FAIL stall_stable got v=%0b %h want v=1 %h", w_m_tvalid,
                   {w_m_tdata, w_m_tkeep, w_m_tlast}, prev_word);
        end
      end
      if (w_m_tvalid && m_tready) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_beat got %h want no beat", w_m_tdata);
          done = 1'b1;
        end else begin
          eb = expQ.pop_front();
          if ({w_m_tdata, w_m_tkeep, w_m_tlast, w_m_tuser} !== {eb.data, eb.keep, eb.last, 1'b0}) begin
            bad++;
            $display("[TB] FAIL beat got d=%h k=%h l=%0b u=%0b want d=%h k=%h l=%0b u=0",
                     w_m_tdata, w_m_tkeep, w_m_tlast, w_m_tuser, eb.data, eb.keep, eb.last);
          end
          if (w_m_tlast) done = 1'b1;
        end
      end
      prev_stall = w_m_tvalid && !m_tready;
      prev_word = {w_m_tdata, w_m_tkeep, w_m_tlast};
      @(posedge clk);
      #1;
      cyc++;
    end
    m_tready = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL payload_timeout got no tlast within %0d cycles want tlast", budget);
    end
  endtask

  task automatic expect_quiet(input int n, input string name);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (w_m_hdr_valid || w_m_tvalid) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("[TB] FAIL %s got output activity want none", name);
    end
  endtask

  task automatic check_stats(input logic [31:0] rx, input logic [31:0] tx, input logic [31:0] drop,
                             input string name);
    total++;
    if ({w_rx, w_tx, w_drop} !== {rx, tx, drop}) begin
      bad++;
      $display("[TB] FAIL %s got rx=%0d tx=%0d drop=%0d want rx=%0d tx=%0d drop=%0d",
               name, w_rx, w_tx, w_drop, rx, tx, drop);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({w_hdr_ready, w_s_tready, w_m_hdr_valid, w_m_tvalid} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_handshakes got %b want 0000",
               {w_hdr_ready, w_s_tready, w_m_hdr_valid, w_m_tvalid});
    end
    check_stats(0, 0, 0, "reset_stats");
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (w_hdr_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hdr_ready_early got %b want 0", w_hdr_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (w_hdr_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hdr_ready_after_reset got %b want 1", w_hdr_ready);
    end
  endtask

  task automatic test_echo();
    int st;
    sel = 1'b0;
    do_reset();
    stim[0] = '{data: 64'hDE, keep: 8'h01, last: 1'b0};
    stim[1] = '{data: 64'hAD, keep: 8'h01, last: 1'b0};
    stim[2] = '{data: 64'hBE, keep: 8'h01, last: 1'b0};
    stim[3] = '{data: 64'hEF, keep: 8'h01, last: 1'b0};
    send_hdr(32'h0A000002, 16'd5000, 16'd1234, 16'd12, 1'b1);
    send_payload(4, 4, 1'b0, 1'b1, st);
    total++;
    if (w_m_hdr_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hdr_latency got m_hdr_valid=%b want 1", w_m_hdr_valid);
    end
    collect(200);
    check_stats(1, 1, 0, "echo_stats");
  endtask

  task automatic test_filter();
    int st;
    sel = 1'b0;
    do_reset();
    fill_bytes(3, 8'h30);
    send_hdr(32'h0A000003, 16'd4000, 16'd80, 16'd11, 1'b0);
    send_payload(3, 3, 1'b0, 1'b0, st);
    expect_quiet(20, "filter_quiet");
    check_stats(1, 0, 1, "filter_stats");
  endtask

  task automatic test_bad_frame();
    int st;
    sel = 1'b0;
    do_reset();
    fill_bytes(5, 8'h40);
    send_hdr(32'h0A000004, 16'd6000, 16'd1234, 16'd13, 1'b0);
    send_payload(5, 5, 1'b1, 1'b0, st);
    expect_quiet(15, "bad_frame_quiet");
    check_stats(1, 0, 1, "bad_frame_stats");
    fill_bytes(6, 8'h90);
    send_hdr(32'h0A000005, 16'd6001, 16'd1234, 16'd14, 1'b1);
    send_payload(6, 6, 1'b0, 1'b1, st);
    collect(200);
    check_stats(2, 1, 1, "after_bad_stats");
  endtask

  task automatic test_overflow();
    int st;
    sel = 1'b0;
    do_reset();
    fill_bytes(20, 8'h00);
    send_hdr(32'h0A000006, 16'd7000, 16'd1234, 16'd28, 1'b0);
    send_payload(20, 20, 1'b0, 1'b0, st);
    total++;
    if (st != 0) begin
      bad++;
      $display("[TB] FAIL overflow_tready got %0d stalled beats want 0", st);
    end
    total++;
    if ({w_s_tready, w_hdr_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL overflow_idle got tready/hdr_ready=%b want 01", {w_s_tready, w_hdr_ready});
    end
    expect_quiet(15, "overflow_quiet");
    check_stats(1, 0, 1, "overflow_stats");
  endtask

  task automatic test_full_frame();
    int st;
    sel = 1'b0;
    do_reset();
    fill_bytes(16, 8'hA0);
    send_hdr(32'hC0A80001, 16'd1111, 16'd1234, 16'd24, 1'b1);
    send_payload(16, 16, 1'b0, 1'b1, st);
    collect(300);
    check_stats(1, 1, 0, "full_frame_stats");
  endtask

  task automatic test_back_to_back();
    int st;
    sel = 1'b0;
    do_reset();
    stim[0] = '{data: 64'h5A, keep: 8'h01, last: 1'b0};
    send_hdr(32'h0A000007, 16'd2000, 16'd1234, 16'd9, 1'b1);
    send_payload(1, 1, 1'b0, 1'b1, st);
    total++;
    if (w_m_hdr_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_beat_hdr got m_hdr_valid=%b want 1", w_m_hdr_valid);
    end
    collect(100);
    fill_bytes(2, 8'h71);
    send_hdr(32'h0A000008, 16'd2001, 16'd1234, 16'd10, 1'b1);
    send_payload(2, 2, 1'b0, 1'b1, st);
    collect(100);
    check_stats(2, 2, 0, "b2b_stats");
  endtask

  task automatic test_reset_mid();
    int st;
    sel = 1'b0;
    do_reset();
    fill_bytes(8, 8'hC0);
    send_hdr(32'h0A000009, 16'd3000, 16'd1234, 16'd16, 1'b0);
    send_payload(3, 8, 1'b0, 1'b0, st);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({w_hdr_ready, w_s_tready, w_m_hdr_valid, w_m_tvalid} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_reset_handshakes got %b want 0000",
               {w_hdr_ready, w_s_tready, w_m_hdr_valid, w_m_tvalid});
    end
    check_stats(0, 0, 0, "mid_reset_stats");
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_quiet(12, "mid_reset_quiet");
    fill_bytes(4, 8'hE0);
    send_hdr(32'h0A00000A, 16'd3001, 16'd1234, 16'd12, 1'b1);
    send_payload(4, 4, 1'b0, 1'b1, st);
    collect(200);
    check_stats(1, 1, 0, "restart_stats");
  endtask

  task automatic test_wide();
    int st;
    sel = 1'b1;
    do_reset();
    stim[0] = '{data: 64'h1716151413121110, keep: 8'hFF, last: 1'b0};
    stim[1] = '{data: 64'h00000000001A1918, keep: 8'h07, last: 1'b0};
    send_hdr(32'h0A00000B, 16'd5555, 16'd1234, 16'd19, 1'b1);
    send_payload(2, 2, 1'b0, 1'b1, st);
    collect(300);
    check_stats(1, 1, 0, "wide_stats");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_echo();
    test_filter();
    test_bad_frame();
    test_overflow();
    test_full_frame();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    total++;
    if (expQ.size() != 0 || hdrQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover got beats=%0d headers=%0d want 0 0", expQ.size(), hdrQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
